// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serializes DSP samples into {CMD_WORD, sample} SPI mode-0 frames.
// One frame per sample_tick; repeats the last sample and flags an underrun when starved.
module dac_spi_tx #(
    parameter int                  CLK_DIV    = 4,
    parameter int                  DATA_WIDTH = 16,
    parameter int                  CMD_BITS   = 8,
    parameter logic [CMD_BITS-1:0] CMD_WORD   = 8'h30
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  dac_axi_valid,
    input  logic [DATA_WIDTH-1:0] dac_axi_data,
    output logic                  dac_axi_ready,
    input  logic                  sample_tick,
    input  logic                  flag_clr,
    output logic                  dac_cs_n,
    output logic                  dac_sclk,
    output logic                  dac_mosi,
    output logic                  busy,
    output logic                  underrun,
    output logic                  tick_overrun
);

    localparam int FB    = CMD_BITS + DATA_WIDTH;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FB > 1) ? $clog2(FB) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(FB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t                state, state_n;
    logic [DIV_W-1:0]      div_cnt, div_n;
    logic [BIT_W-1:0]      bit_cnt, bit_n;
    logic [FB-1:0]         shreg, sh_n;
    logic                  cs_n_q, cs_n_n;
    logic                  sclk_q, sclk_n;
    logic                  mosi_q, mosi_n;

    logic                  full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] last_sample;
    logic                  underrun_q;
    logic                  overrun_q;

    logic                  div_last;
    logic                  start;
    logic                  tick_lost;
    logic [FB-1:0]         frame_word;

    assign div_last   = (div_cnt == DIV_MAX);
    // The last HOLD cycle may accept a tick so frames can run back-to-back.
    assign start      = sample_tick &&
                        ((state == S_IDLE) ||
                         ((state == S_HOLD) && div_last));
    assign tick_lost  = sample_tick && !start;
    assign frame_word = {CMD_WORD, full ? hold_data : last_sample};

    always_comb begin
        state_n = state;
        div_n   = div_last ? '0 : div_cnt + DIV_W'(1);
        bit_n   = bit_cnt;
        sh_n    = shreg;
        cs_n_n  = cs_n_q;
        sclk_n  = sclk_q;
        mosi_n  = mosi_q;
        unique case (state)
            S_IDLE: begin
                div_n = '0;
            end
            S_SETUP: begin
                if (div_last) begin
                    state_n = S_SHIFT;
                    sclk_n  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_last) begin
                    if (sclk_q) begin
                        sclk_n = 1'b0;
                        if (bit_cnt != BIT_MAX) begin
                            sh_n   = {shreg[FB-2:0], 1'b0};
                            mosi_n = shreg[FB-2];
                        end
                    end else if (bit_cnt == BIT_MAX) begin
                        state_n = S_HOLD;
                        cs_n_n  = 1'b1;
                        mosi_n  = 1'b0;
                    end else begin
                        sclk_n = 1'b1;
                        bit_n  = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (start) begin
            state_n = S_SETUP;
            div_n   = '0;
            bit_n   = '0;
            sh_n    = frame_word;
            cs_n_n  = 1'b0;
            sclk_n  = 1'b0;
            mosi_n  = frame_word[FB-1];
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            cs_n_q  <= cs_n_n;
            sclk_q  <= sclk_n;
            mosi_q  <= mosi_n;
        end
    end

    // A word arriving with an underrun tick is still captured for the next frame.
    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn) begin
            full        <= 1'b0;
            hold_data   <= '0;
            last_sample <= '0;
        end else begin
            if (start) begin
                full <= 1'b0;
                if (full) begin
                    last_sample <= hold_data;
                end
            end
            if (dac_axi_valid && !full) begin
                full      <= 1'b1;
                hold_data <= dac_axi_data;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn) begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (start && !full) begin
                underrun_q <= 1'b1;
            end else if (flag_clr) begin
                underrun_q <= 1'b0;
            end
            if (tick_lost) begin
                overrun_q <= 1'b1;
            end else if (flag_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign dac_axi_ready = !full;
    assign dac_cs_n      = cs_n_q;
    assign dac_sclk      = sclk_q;
    assign dac_mosi      = mosi_q;
    assign busy          = (state != S_IDLE);
    assign underrun      = underrun_q;
    assign tick_overrun  = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed bench for dac_spi_tx with an SPI capture monitor.
// Default parameters: CLK_DIV=4, 24-bit frames, 200-cycle frame period.
module tb_dac_spi_tx;

    logic        axis_aclk;
    logic        axis_aresetn;
    logic        dac_axi_valid;
    logic [15:0] dac_axi_data;
    logic        dac_axi_ready;
    logic        sample_tick;
    logic        flag_clr;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        busy;
    logic        underrun;
    logic        tick_overrun;

    int checks   = 0;
    int failures = 0;

    logic [23:0] cap   = '0;
    int          rises = 0;

    int          f_cs_rise;
    int          f_rises;
    logic [23:0] f_word;
    logic        f_cs0;
    logic        f_busy0;
    logic        f_ready0;
    logic        f_under0;
    logic        f_busy199;
    logic        f_ovr;

    dac_spi_tx dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .dac_axi_valid (dac_axi_valid),
        .dac_axi_data  (dac_axi_data),
        .dac_axi_ready (dac_axi_ready),
        .sample_tick   (sample_tick),
        .flag_clr      (flag_clr),
        .dac_cs_n      (dac_cs_n),
        .dac_sclk      (dac_sclk),
        .dac_mosi      (dac_mosi),
        .busy          (busy),
        .underrun      (underrun),
        .tick_overrun  (tick_overrun)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    always @(posedge dac_sclk) begin
        cap   <= {cap[22:0], dac_mosi};
        rises <= rises + 1;
    end

    task automatic step();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has sample_tick set; the next edge is edge 0 of the frame.
    // Returns at the observation point after edge 199.
    task automatic run_frame(input int extra_at, input bit chain);
        int r0;
        r0 = rises;
        step();
        sample_tick = 1'b0;
        f_cs0     = dac_cs_n;
        f_busy0   = busy;
        f_ready0  = dac_axi_ready;
        f_under0  = underrun;
        f_cs_rise = -1;
        for (int c = 1; c < 200; c++) begin
            sample_tick = (c == extra_at);
            if (c == 2) dac_axi_valid = 1'b0;
            step();
            sample_tick = 1'b0;
            if (dac_cs_n && f_cs_rise < 0) f_cs_rise = c;
        end
        f_busy199 = busy;
        f_ovr     = tick_overrun;
        f_word    = cap;
        f_rises   = rises - r0;
        if (chain) sample_tick = 1'b1;
    endtask

    initial begin
        axis_aresetn  = 1'b1;
        dac_axi_valid = 1'b0;
        dac_axi_data  = '0;
        sample_tick   = 1'b0;
        flag_clr      = 1'b0;
        step();
        step();
        chk("rst_cs_n", 32'(dac_cs_n), 32'd1);
        chk("rst_sclk", 32'(dac_sclk), 32'd0);
        chk("rst_mosi", 32'(dac_mosi), 32'd0);
        chk("rst_ready", 32'(dac_axi_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_under", 32'(underrun), 32'd0);
        chk("rst_ovr", 32'(tick_overrun), 32'd0);
        axis_aresetn = 1'b0;
        step();

        // Basic frame
        dac_axi_valid = 1'b1;
        dac_axi_data  = 16'hA5C3;
        step();
        dac_axi_valid = 1'b0;
        chk("basic_ready_full", 32'(dac_axi_ready), 32'd0);
        step();
        sample_tick = 1'b1;
        run_frame(-1, 1'b0);
        chk("basic_cs0", 32'(f_cs0), 32'd0);
        chk("basic_busy0", 32'(f_busy0), 32'd1);
        chk("basic_ready0", 32'(f_ready0), 32'd1);
        chk("basic_word", 32'(f_word), 32'h30A5C3);
        chk("basic_rises", 32'(f_rises), 32'd24);
        chk("basic_cs_rise", 32'(f_cs_rise), 32'd196);
        chk("basic_busy199", 32'(f_busy199), 32'd1);
        step();
        chk("basic_busy200", 32'(busy), 32'd0);
        chk("basic_under", 32'(underrun), 32'd0);

        // Underrun repeat
        sample_tick = 1'b1;
        run_frame(-1, 1'b0);
        step();
        chk("und_flag0", 32'(f_under0), 32'd1);
        chk("und_word", 32'(f_word), 32'h30A5C3);
        chk("und_rises", 32'(f_rises), 32'd24);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("und_clr", 32'(underrun), 32'd0);
        chk("und_no_ovr", 32'(tick_overrun), 32'd0);

        // Overrun: tick at 100 ignored, tick at 200 accepted
        sample_tick = 1'b1;
        run_frame(100, 1'b1);
        chk("ovr_flag", 32'(f_ovr), 32'd1);
        chk("ovr_cs_rise", 32'(f_cs_rise), 32'd196);
        chk("ovr_rises", 32'(f_rises), 32'd24);
        chk("ovr_word", 32'(f_word), 32'h30A5C3);
        run_frame(-1, 1'b0);
        chk("ovr_next_cs0", 32'(f_cs0), 32'd0);
        chk("ovr_next_busy0", 32'(f_busy0), 32'd1);
        chk("ovr_next_word", 32'(f_word), 32'h30A5C3);
        chk("ovr_next_cs_rise", 32'(f_cs_rise), 32'd196);
        step();
        chk("ovr_next_busy200", 32'(busy), 32'd0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("ovr_clr", 32'(tick_overrun), 32'd0);
        chk("ovr_clr_under", 32'(underrun), 32'd0);

        // Back-pressure ordering
        dac_axi_valid = 1'b1;
        dac_axi_data  = 16'h1111;
        step();
        dac_axi_data = 16'h2222;
        chk("bp_stall", 32'(dac_axi_ready), 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("bp_still_stall", 32'(dac_axi_ready), 32'd0);
        sample_tick = 1'b1;
        run_frame(-1, 1'b1);
        chk("bp_word1", 32'(f_word), 32'h301111);
        chk("bp_ready_full", 32'(dac_axi_ready), 32'd0);
        run_frame(-1, 1'b0);
        chk("bp_word2", 32'(f_word), 32'h302222);
        chk("bp_rises2", 32'(f_rises), 32'd24);
        step();
        chk("bp_busy200", 32'(busy), 32'd0);
        chk("bp_under", 32'(underrun), 32'd0);
        chk("bp_ovr", 32'(tick_overrun), 32'd0);
        chk("bp_ready", 32'(dac_axi_ready), 32'd1);

        // Reset during bit 10
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int i = 0; i < 86; i++) step();
        chk("mid_sclk_high", 32'(dac_sclk), 32'd1);
        axis_aresetn = 1'b1;
        step();
        axis_aresetn = 1'b0;
        chk("mid_cs_n", 32'(dac_cs_n), 32'd1);
        chk("mid_sclk", 32'(dac_sclk), 32'd0);
        chk("mid_mosi", 32'(dac_mosi), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(dac_axi_ready), 32'd1);
        step();
        sample_tick = 1'b1;
        run_frame(-1, 1'b0);
        step();
        chk("mid_word", 32'(f_word), 32'h300000);
        chk("mid_rises", 32'(f_rises), 32'd24);
        chk("mid_under", 32'(underrun), 32'd1);
        chk("mid_busy200", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serializes the DSP output sample stream onto the SPI bus of the audio DAC. Sits downstream of `digital_signal_processor`, consuming its `dac_axi_valid`/`dac_axi_data` stream, and replaces the simulation-only AXI DAC path with real SPI frames.

- One frame is launched per audio-rate `sample_tick`.
- If no new sample has arrived by the tick, the block repeats the last sample and flags an underrun.

## Interface

Parameters:
- CLK_DIV, 4: SCLK half-period in `axis_aclk` cycles. Must be ≥1.
- DATA_WIDTH, 16: sample width.
- CMD_BITS, 8: width of the command prefix.
- CMD_WORD, 8'h30: command prefix sent ahead of every sample ("write and update DAC A").

Ports:
- axis_aclk  in  1  system clock; all logic is on its rising edge.
- axis_aresetn  in  1  synchronous, active-high reset.
- dac_axi_valid  in  1  sample valid from the DSP.
- dac_axi_data  in  DATA_WIDTH  sample from the DSP, unsigned.
- dac_axi_ready  out  1  holding register empty; a transfer occurs on `valid && ready`.
- sample_tick  in  1  single-cycle pulse at the audio rate; requests a frame.
- flag_clr  in  1  clears both sticky flags.
- dac_cs_n  out  1  SPI chip select, active low.
- dac_sclk  out  1  SPI clock, mode 0 (idles low, data sampled on the rising edge).
- dac_mosi  out  1  SPI data, MSB first.
- busy  out  1  a frame or the recovery gap is in progress.
- underrun  out  1  sticky: a tick found the holding register empty.
- tick_overrun  out  1  sticky: a tick arrived while `busy` was high.

## Operation

Frame format:
- FRAME_BITS = CMD_BITS + DATA_WIDTH (24 by default).
- Frame content is {CMD_WORD, sample}, sent MSB first.

Holding register:
- A one-entry register with a full bit.
- `dac_axi_ready` = !full.
- Frame start empties the register; `ready` is high the cycle after frame start.

Last sample:
- `last_sample` resets to 0.
- It is updated with every sample that is sent in a frame.

State machine:
- IDLE
  - `sample_tick` → SETUP.
  - Loads the shifter with {CMD_WORD, full ? hold_data : last_sample}.
  - If the register was empty, sets `underrun`.
- SETUP: lasts CLK_DIV cycles; `cs_n`=0, `sclk`=0, `mosi`=frame MSB.
- SHIFT: one step per bit, FRAME_BITS bits in total.
  - `sclk`=1 for CLK_DIV cycles, then `sclk`=0 for CLK_DIV cycles.
  - The shifter advances on each high→low transition, except after the last bit.
  - After the final low phase → HOLD.
- HOLD: lasts CLK_DIV cycles; `cs_n`=1, `sclk`=0, `mosi`=0. Then → IDLE.

Busy and flags:
- `busy` = (state != IDLE).
- `sample_tick` while `busy` is ignored and sets `tick_overrun`.
- `flag_clr` clears both flags. If a set and a clear land in the same cycle, the set wins.

Simultaneous events:
- Tick in IDLE with the register empty and a `valid` transfer in the same cycle: the frame uses `last_sample` and sets `underrun`; the incoming word is still stored in the holding register.
- Tick with the register full and `valid` high: `ready` is 0, so nothing is accepted; the word is accepted on the following cycle.

Reset, including mid-frame, takes effect at the next edge:
- state = IDLE
- `cs_n`=1, `sclk`=0, `mosi`=0
- holding register empty, so `ready`=1
- `last_sample`=0
- `busy`, `underrun` and `tick_overrun` = 0

All SPI outputs are registered; there is no combinational path from the inputs to the SPI pins.

## Timing

Let tick be sampled at edge 0. Defaults give CLK_DIV=4 and FRAME_BITS=24.
- Edge 0: `cs_n`↓, `busy`↑, `mosi` = bit 23.
- Rising SCLK edge for bit k (k = 0 for the MSB) falls at edge CLK_DIV·(1+2k).
- `cs_n`↑ at edge CLK_DIV·(1+2·FRAME_BITS) = 196.
- `busy`↓ at edge CLK_DIV·(2+2·FRAME_BITS) = 200.
- Minimum tick spacing with no overrun: 200 cycles. A tick at edge 200 is accepted.
- SCLK frequency is `axis_aclk`/(2·CLK_DIV).
- MOSI is stable for CLK_DIV cycles on either side of every rising SCLK edge.
- Input latency: a sample accepted at edge n is sent by the first tick at or after edge n+1.

## Test plan

- Reset:
  - Assert `axis_aresetn` for 2 cycles.
  - Require `cs_n`=1, `sclk`=0, `mosi`=0, `ready`=1, `busy`=0, `underrun`=0, `tick_overrun`=0.
- Basic frame:
  - Send 16'hA5C3, then tick.
  - The SPI monitor must capture 24'h30A5C3 on 24 rising edges.
  - `cs_n` low for exactly 196 cycles; `busy` low at edge 200; `ready` high from edge 1.
- Underrun repeat:
  - After the basic frame, tick again with no new data.
  - Require 24'h30A5C3 again and `underrun`=1.
  - Pulse `flag_clr`; require `underrun`=0.
- Overrun:
  - Tick at edge 0 and again at edge 100.
  - Require `tick_overrun`=1, a single unbroken frame, and a frame started by a tick at edge 200.
- Back-pressure ordering:
  - Present 16'h1111 then 16'h2222 back-to-back; the second must stall with `ready`=0.
  - Tick at edges 10 and 210.
  - Require frames 24'h301111 then 24'h302222, and no flags set.
- Reset mid-frame:
  - Assert reset during bit 10.
  - Next cycle require `cs_n`=1, `sclk`=0, `busy`=0.
  - Next tick with no data must send 24'h300000 and set `underrun`.
